// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. It resolves, in
//   priority order: a memory freeze while a data access is in flight, a taken
//   branch in MEM, and a load-use hazard in ID. It also keeps a sticky
//   memory-timeout flag and a saturating stall-cycle counter for debug.
//
// Ports
//   Clk, Reset                        clock (rising edge), synchronous active-high reset
//   IDEX_MemRead_in, IDEX_Rt_in       load in EX and its destination register
//   IFID_Rs_in, IFID_Rt_in            source registers of the instruction in ID
//   EXMEM_MemRead_in/MemWrite_in      load/store in MEM (a data memory access)
//   EXMEM_Branch_in, EXMEM_Zero_in    branch in MEM and its ALU zero flag
//   Mem_Ready_in                      data memory access completes this cycle
//   Mem_Req_out                       data memory request
//   PC_Write_out, PC_Src_out          PC load enable, 1 = branch target
//   IFID_Write_out                    IF/ID load enable
//   IDEX_Bubble_out                   zero ID/EX control fields
//   IFID/IDEX/EXMEM_Flush_out         clear the respective stage register
//   EXMEM_Hold_out                    EX/MEM and ID/EX keep their value
//   Mem_Timeout_out                   sticky memory-timeout error
//   Stall_Count_out                   saturating count of cycles with PC_Write_out=0
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IDEX_MemRead_in,
  input  logic [4:0]       IDEX_Rt_in,
  input  logic [4:0]       IFID_Rs_in,
  input  logic [4:0]       IFID_Rt_in,
  input  logic             EXMEM_MemRead_in,
  input  logic             EXMEM_MemWrite_in,
  input  logic             EXMEM_Branch_in,
  input  logic             EXMEM_Zero_in,
  input  logic             Mem_Ready_in,
  output logic             Mem_Req_out,
  output logic             PC_Write_out,
  output logic             PC_Src_out,
  output logic             IFID_Write_out,
  output logic             IDEX_Bubble_out,
  output logic             IFID_Flush_out,
  output logic             IDEX_Flush_out,
  output logic             EXMEM_Flush_out,
  output logic             EXMEM_Hold_out,
  output logic             Mem_Timeout_out,
  output logic [CNT_W-1:0] Stall_Count_out
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0]       TIMEOUT_C = MEM_TIMEOUT[7:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_r, state_nxt_s;
  logic [7:0] wait_cnt_r, wait_nxt_s;
  logic       timeout_set_s;
  logic       freeze_s;
  logic       acc_s, taken_s, lu_s;

  assign acc_s   = EXMEM_MemRead_in | EXMEM_MemWrite_in;
  assign taken_s = EXMEM_Branch_in & EXMEM_Zero_in;
  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu_s    = IDEX_MemRead_in & (IDEX_Rt_in != 5'd0) &
                   ((IDEX_Rt_in == IFID_Rs_in) | (IDEX_Rt_in == IFID_Rt_in));

  // Next-state logic and all combinational control outputs.
  always_comb begin
    state_nxt_s     = state_r;
    wait_nxt_s      = wait_cnt_r;
    timeout_set_s   = 1'b0;
    freeze_s        = 1'b0;
    Mem_Req_out     = 1'b0;
    PC_Write_out    = 1'b0;
    PC_Src_out      = 1'b0;
    IFID_Write_out  = 1'b0;
    IDEX_Bubble_out = 1'b0;
    IFID_Flush_out  = 1'b0;
    IDEX_Flush_out  = 1'b0;
    EXMEM_Flush_out = 1'b0;
    EXMEM_Hold_out  = 1'b0;
    if (Reset) begin
      // Reset clears every stage register and aborts any memory access.
      IFID_Flush_out  = 1'b1;
      IDEX_Flush_out  = 1'b1;
      EXMEM_Flush_out = 1'b1;
      state_nxt_s     = RUN;
      wait_nxt_s      = 8'd0;
    end else begin
      Mem_Req_out = acc_s;
      case (state_r)
        RUN: begin
          if (acc_s && !Mem_Ready_in) begin
            freeze_s    = 1'b1;
            state_nxt_s = MEM_WAIT;
            wait_nxt_s  = 8'd1;
          end else begin
            freeze_s = 1'b0;
          end
        end
        MEM_WAIT: begin
          if (Mem_Ready_in) begin
            state_nxt_s = RUN;
            wait_nxt_s  = 8'd0;
          end else if (wait_cnt_r == TIMEOUT_C) begin
            // Give up on the access: flag it and let the pipeline move on.
            timeout_set_s = 1'b1;
            state_nxt_s   = RUN;
            wait_nxt_s    = 8'd0;
          end else begin
            freeze_s   = 1'b1;
            wait_nxt_s = wait_cnt_r + 8'd1;
          end
        end
        default: begin
          state_nxt_s = RUN;
          wait_nxt_s  = 8'd0;
        end
      endcase

      // A release cycle (ready or timeout) falls through to normal priority.
      if (freeze_s) begin
        EXMEM_Hold_out = 1'b1;
      end else if (taken_s) begin
        PC_Src_out      = 1'b1;
        PC_Write_out    = 1'b1;
        IFID_Flush_out  = 1'b1;
        IDEX_Flush_out  = 1'b1;
        EXMEM_Flush_out = 1'b1;
      end else if (lu_s) begin
        IDEX_Bubble_out = 1'b1;
      end else begin
        PC_Write_out   = 1'b1;
        IFID_Write_out = 1'b1;
      end
    end
  end

  // FSM state and memory-wait cycle counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= RUN;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
    end
  end

  // Sticky timeout flag, cleared only by Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Mem_Timeout_out <= 1'b0;
    end else if (timeout_set_s) begin
      Mem_Timeout_out <= 1'b1;
    end else begin
      Mem_Timeout_out <= Mem_Timeout_out;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Stall_Count_out <= '0;
    end else if (!PC_Write_out && (Stall_Count_out != CNT_MAX)) begin
      Stall_Count_out <= Stall_Count_out + CNT_ONE;
    end else begin
      Stall_Count_out <= Stall_Count_out;
    end
  end

endmodule
